// File: rtl/ce_burst_arbiter_if.sv
// Bus between requesters and the burst arbiter: request vector in, burst status out.
interface ce_burst_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] grant;
   logic            ce;
   logic            busy;
   logic            done;
   logic [OW-1:0]   owner;

   // Requester side drives req and observes the arbiter status.
   modport master (
      output req,
      input  grant,
      input  ce,
      input  busy,
      input  done,
      input  owner
   );

   // Arbiter side samples req and drives the registered status.
   modport slave (
      input  req,
      output grant,
      output ce,
      output busy,
      output done,
      output owner
   );
endinterface

// File: rtl/ce_burst_arbiter.sv
// Round-robin arbiter handing out fixed-length clock-enable bursts separated by a
// minimum low gap, so the shared datapath never sees a short or long ce pulse.
module ce_burst_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned GAP_LEN   = 1
) (
   input logic                 clk,
   input logic                 rst,
   ce_burst_arbiter_if.slave   bus
);

   localparam int unsigned OW = (NREQ > 1)      ? $clog2(NREQ)      : 1;
   localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned GW = (GAP_LEN > 1)   ? $clog2(GAP_LEN)   : 1;
   localparam int unsigned RW = $clog2(BURST_LEN + 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t          r_state;
   logic [NREQ-1:0] r_grant;
   logic            r_ce;
   logic            r_busy;
   logic            r_done;
   logic [OW-1:0]   r_owner;
   logic [OW-1:0]   r_rr_ptr;
   logic [CW-1:0]   r_cnt;
   logic [GW-1:0]   r_gcnt;
   logic [RW-1:0]   r_run;

   logic            w_any;
   logic [OW-1:0]   w_win;
   logic [OW-1:0]   w_next_ptr;
   int unsigned     w_idx;

   // Round-robin scan starting at r_rr_ptr; first asserted request wins.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      w_idx = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_idx = 32'(r_rr_ptr) + i;
         if (w_idx >= NREQ) begin
            w_idx = w_idx - NREQ;
         end
         if (!w_any && bus.req[OW'(w_idx)]) begin
            w_any = 1'b1;
            w_win = OW'(w_idx);
         end
      end
      w_next_ptr = (w_win == OW'(NREQ - 1)) ? '0 : OW'(w_win + OW'(1));
   end

   // Burst FSM: IDLE -> BURST (BURST_LEN ce cycles) -> GAP (GAP_LEN cycles) -> IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_ce     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_owner  <= '0;
         r_rr_ptr <= '0;
         r_cnt    <= '0;
         r_gcnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (w_any) begin
                  r_state  <= S_BURST;
                  r_ce     <= 1'b1;
                  r_busy   <= 1'b1;
                  r_grant  <= NREQ'(1) << w_win;
                  r_owner  <= w_win;
                  r_rr_ptr <= w_next_ptr;
                  r_cnt    <= CW'(BURST_LEN - 1);
               end
            end
            S_BURST: begin
               if (r_cnt == '0) begin
                  r_state <= S_GAP;
                  r_ce    <= 1'b0;
                  r_grant <= '0;
                  r_done  <= 1'b1;
                  r_gcnt  <= GW'(GAP_LEN - 1);
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_GAP: begin
               r_done <= 1'b0;
               if (r_gcnt == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gcnt <= r_gcnt - GW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ce    <= 1'b0;
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant = r_grant;
   assign bus.ce    = r_ce;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.owner = r_owner;

   // Length of the current/just-ended ce-high run, saturating above BURST_LEN.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_run <= '0;
      end else if (r_ce) begin
         if (r_run != RW'(BURST_LEN + 1)) begin
            r_run <= r_run + RW'(1);
         end
      end else begin
         r_run <= '0;
      end
   end

   // A completed ce pulse must be exactly BURST_LEN cycles long.
   a_pulse_exact: assert property (@(posedge clk) disable iff (rst)
      (!r_ce && (r_run != '0)) |-> (r_run == RW'(BURST_LEN)));

   // ce never stays high beyond BURST_LEN cycles.
   a_pulse_not_long: assert property (@(posedge clk) disable iff (rst)
      r_ce |-> (r_run < RW'(BURST_LEN)));

   // Grant is one-hot or zero, and nonzero exactly when ce is high.
   a_grant_ce: assert property (@(posedge clk) disable iff (rst)
      $onehot0(r_grant) && ((r_grant != '0) == r_ce));

endmodule

// File: tb/tb_ce_burst_arbiter.sv
// Directed bench for ce_burst_arbiter: default configuration plus a
// single-cycle-burst / long-gap configuration sharing clock and reset.
module tb_ce_burst_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_err;

   ce_burst_arbiter_if #(.NREQ(4)) a_if ();
   ce_burst_arbiter_if #(.NREQ(4)) b_if ();

   ce_burst_arbiter #(.NREQ(4), .BURST_LEN(16), .GAP_LEN(1)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );

   ce_burst_arbiter #(.NREQ(4), .BURST_LEN(1), .GAP_LEN(3)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic ce_of(input bit sel);
      return sel ? b_if.ce : a_if.ce;
   endfunction

   function automatic logic [3:0] grant_of(input bit sel);
      return sel ? b_if.grant : a_if.grant;
   endfunction

   function automatic logic [4:0] status_of(input bit sel);
      // {busy, done, owner[1:0], ce}
      return sel ? {b_if.busy, b_if.done, b_if.owner, b_if.ce}
                 : {a_if.busy, a_if.done, a_if.owner, a_if.ce};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called on the first ce-high cycle; returns on the first ce-low cycle after it.
   task automatic run_burst(input bit sel, input logic [3:0] eg, input int elen,
                            input logic [1:0] eo);
      int len;
      bit stable;
      logic [4:0] st;
      st = status_of(sel);
      check("burst_start_ce", 32'(st[0]), 32'd1);
      check("burst_start_grant", 32'(grant_of(sel)), 32'(eg));
      check("burst_owner", 32'(st[2:1]), 32'(eo));
      check("burst_busy", 32'(st[4]), 32'd1);
      len = 0;
      stable = 1'b1;
      while (ce_of(sel) === 1'b1 && len < 64) begin
         len++;
         if (grant_of(sel) !== eg) stable = 1'b0;
         @(negedge clk);
      end
      st = status_of(sel);
      check("burst_len", 32'(len), 32'(elen));
      check("burst_grant_stable", 32'(stable), 32'd1);
      check("done_pulse", 32'(st[3]), 32'd1);
      check("gap_grant_zero", 32'(grant_of(sel)), 32'd0);
      check("gap_busy", 32'(st[4]), 32'd1);
   endtask

   // Called on a ce-low cycle; counts low cycles until ce rises (bounded).
   task automatic count_low(input bit sel, output int low);
      low = 0;
      while (ce_of(sel) === 1'b0 && low < 32) begin
         low++;
         @(negedge clk);
      end
   endtask

   logic [3:0] rr_exp [5];
   int         low;

   // Directed stimulus sequence.
   initial begin
      n_checks  = 0;
      n_err     = 0;
      rst       = 1'b1;
      a_if.req  = '0;
      b_if.req  = '0;
      rr_exp[0] = 4'b0001;
      rr_exp[1] = 4'b0010;
      rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000;
      rr_exp[4] = 4'b0001;

      // 1: reset then idle with no requests
      repeat (2) @(negedge clk);
      check("rst_a_status", 32'(status_of(1'b0)), 32'd0);
      check("rst_a_grant", 32'(a_if.grant), 32'd0);
      check("rst_b_status", 32'(status_of(1'b1)), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_ce", 32'(a_if.ce), 32'd0);
         check("idle_grant", 32'(a_if.grant), 32'd0);
         check("idle_busy", 32'(a_if.busy), 32'd0);
      end

      // 2: single requester held -> back-to-back bursts with 2 low cycles
      a_if.req = 4'b0001;
      @(negedge clk);
      run_burst(1'b0, 4'b0001, 16, 2'd0);
      @(negedge clk);
      check("t2_idle_ce", 32'(a_if.ce), 32'd0);
      check("t2_idle_busy", 32'(a_if.busy), 32'd0);
      check("t2_idle_done", 32'(a_if.done), 32'd0);
      @(negedge clk);
      run_burst(1'b0, 4'b0001, 16, 2'd0);
      a_if.req = '0;
      repeat (2) @(negedge clk);
      check("t2_quiet_ce", 32'(a_if.ce), 32'd0);

      // 3: all requesting from reset -> rotating grants with wrap
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      a_if.req = 4'b1111;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         run_burst(1'b0, rr_exp[k], 16, (k == 4) ? 2'd0 : 2'(k));
         if (k == 4) a_if.req = '0;
         count_low(1'b0, low);
         if (k != 4) check("t3_gap_low", 32'(low), 32'd2);
      end
      check("t3_final_idle_busy", 32'(a_if.busy), 32'd0);

      // 4: one-cycle request pulse still gets a full burst
      a_if.req = 4'b0100;
      @(negedge clk);
      a_if.req = '0;
      run_burst(1'b0, 4'b0100, 16, 2'd2);
      repeat (2) @(negedge clk);
      check("t4_idle_ce", 32'(a_if.ce), 32'd0);
      check("t4_idle_busy", 32'(a_if.busy), 32'd0);
      check("t4_idle_grant", 32'(a_if.grant), 32'd0);

      // 5: reset at burst cycle 8 truncates, pointer restarts
      a_if.req = 4'b0001;
      @(negedge clk);
      repeat (7) @(negedge clk);
      check("t5_cycle8_ce", 32'(a_if.ce), 32'd1);
      check("t5_cycle8_grant", 32'(a_if.grant), 32'b0001);
      rst = 1'b1;
      a_if.req = '0;
      @(negedge clk);
      check("t5_rst_status", 32'(status_of(1'b0)), 32'd0);
      check("t5_rst_grant", 32'(a_if.grant), 32'd0);
      rst = 1'b0;
      a_if.req = 4'b1000;
      @(negedge clk);
      run_burst(1'b0, 4'b1000, 16, 2'd3);
      a_if.req = '0;
      repeat (2) @(negedge clk);

      // 6: BURST_LEN=1, GAP_LEN=3 alternating between two requesters
      b_if.req = 4'b0011;
      @(negedge clk);
      run_burst(1'b1, 4'b0001, 1, 2'd0);
      count_low(1'b1, low);
      check("t6_gap_low_1", 32'(low), 32'd4);
      run_burst(1'b1, 4'b0010, 1, 2'd1);
      count_low(1'b1, low);
      check("t6_gap_low_2", 32'(low), 32'd4);
      run_burst(1'b1, 4'b0001, 1, 2'd0);
      b_if.req = '0;
      repeat (4) @(negedge clk);
      check("t6_end_busy", 32'(b_if.busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
